// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word assembler with selectable bit order, one output register
// and a one-word holding slot so a finished word can wait for the consumer.
module serial_word_receiver #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  logic             accept;
  logic             out_free;
  logic             dir_eff;
  int               pos;
  logic [WIDTH-1:0] word_ins;

  assign sin_ready = (state_q != STALL) && !clr;
  assign accept    = sin_valid && sin_ready;
  assign out_free  = !q_valid_q || q_ready;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    dir_d     = dir_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;

    // The first bit of a word uses the live dir; later bits use the latched copy.
    dir_eff  = (state_q == IDLE) ? dir : dir_q;
    pos      = dir_eff ? (WIDTH - 1 - int'(cnt_q)) : int'(cnt_q);
    word_ins = (state_q == IDLE) ? '0 : word_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == pos) word_ins[k] = sin;
    end

    // Consumer handshake; a word loaded on this same edge overrides it below.
    if (q_valid_q && q_ready) q_valid_d = 1'b0;

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        STALL: begin
          if (q_ready) begin
            q_d       = word_q;
            q_valid_d = 1'b1;
            word_d    = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (state_q == IDLE) dir_d = dir;
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
              if (out_free) begin
                q_d       = word_ins;
                q_valid_d = 1'b1;
                word_d    = '0;
                state_d   = IDLE;
              end else begin
                word_d  = word_ins;
                state_d = STALL;
              end
            end else begin
              cnt_d   = cnt_q + CW'(1);
              word_d  = word_ins;
              state_d = RECV;
            end
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      dir_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver (WIDTH=4): directed scenarios plus random traffic,
// scored against a queue-based model of accepted bits and pending words.
module tb_serial_word_receiver;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          sin_valid;
  logic          sin_ready;
  logic          dir;
  logic          clr;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          q_ready;
  logic [CW-1:0] bit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bits of the word in progress, and words inside the DUT not yet consumed
  // (front = output register, second entry = word waiting in the holding slot).
  logic         bits[$];
  logic         cur_dir;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready),
    .dir       (dir),
    .clr       (clr),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (cur_dir) w[W-1-k] = bits[k];
      else         w[k]     = bits[k];
    end
    return w;
  endfunction

  // Called at posedge+1; drives one cycle of inputs and advances the model over the edge.
  task automatic step(input logic v, input logic s, input logic d, input logic c, input logic qr);
    logic held, exp_ready, acc;
    sin_valid = v;
    sin       = s;
    dir       = d;
    clr       = c;
    q_ready   = qr;
    held      = (exp_q.size() == 2);
    exp_ready = !c && !held;
    acc       = v && exp_ready;
    #1 check("sin_ready", sin_ready, exp_ready);
    @(posedge clk);
    if (c) begin
      bits.delete();
      if (held) void'(exp_q.pop_back());
    end else if (acc) begin
      if (bits.size() == 0) cur_dir = d;
      bits.push_back(s);
      if (bits.size() == W) begin
        exp_q.push_back(build_word());
        bits.delete();
      end
    end
    #1;
  endtask

  task automatic send4(input logic [3:0] b, input logic d, input logic qr);
    for (int i = 0; i < 4; i++) step(1'b1, b[i], d, 1'b0, qr);
  endtask

  // Scoreboard monitor: compares outputs mid-cycle and retires words on handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("q_valid", q_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("q_word", q, exp_q[0]);
        else                   check("q_hold", q, last_q);
        check("bit_cnt", bit_cnt, bits.size());
        if (exp_q.size() != 0 && q_ready) last_q = exp_q.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; clr = 1'b0; q_ready = 1'b0;
    cur_dir = 1'b0; last_q = '0;
    #2;
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_sin_ready", sin_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // LSB-first 1,1,0,1 -> 1011, consumed one edge later
    send4(4'b1011, 1'b0, 1'b1);
    check("lsb_q", q, 4'b1011);
    check("lsb_q_valid", q_valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lsb_consumed", q_valid, 0);
    check("lsb_q_held", q, 4'b1011);

    // MSB-first 1,0,1,1 with dir toggled after bit 2 -> 1011
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_q", q, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: 1011 then 0110 with q_ready low -> STALL
    send4(4'b1011, 1'b0, 1'b0);
    send4(4'b0110, 1'b0, 1'b0);
    check("stall_sin_ready", sin_ready, 0);
    check("stall_q", q, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("unstall_q", q, 4'b0110);
    check("unstall_q_valid", q_valid, 1);
    check("unstall_sin_ready", sin_ready, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after two bits; the bit offered with clr is dropped
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_bit_cnt", bit_cnt, 0);
    send4(4'b0110, 1'b0, 1'b1);
    check("clr_q", q, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Consume and complete on the same edge: no STALL
    send4(4'b1001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("simul_q", q, 4'b1010);
    check("simul_q_valid", q_valid, 1);
    check("simul_sin_ready", sin_ready, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with three bits held and q valid
    send4(4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_bit_cnt", bit_cnt, 3);
    check("pre_rst_q_valid", q_valid, 1);
    sin_valid = 1'b0; q_ready = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_q", q, 0);
    check("arst_q_valid", q_valid, 0);
    check("arst_bit_cnt", bit_cnt, 0);
    check("arst_sin_ready", sin_ready, 1);
    exp_q.delete(); bits.delete(); last_q = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    send4(4'b1110, 1'b0, 1'b1);
    check("post_rst_q", q, 4'b1110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
